// File: rtl/register_file_reader.sv
// Streams register-file contents as single reads or whole-file snapshot scans.
// Beat valid one cycle after the request edge; beats hold while out_ready is low.
module register_file_reader #(
    parameter int WIDTH     = 16,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*NUM_REGS-1:0] regs_flat,
    input  logic                      rd_req,
    input  logic [ADDR_BITS-1:0]      rd_addr,
    input  logic                      scan_start,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [ADDR_BITS-1:0]      out_addr,
    output logic                      out_last,
    output logic                      out_err
);

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        SCAN
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_REGS - 1);

    state_t                      state_q, state_d;
    logic [WIDTH*NUM_REGS-1:0]   snap_q, snap_d;
    logic [ADDR_BITS-1:0]        idx_q, idx_d;
    logic                        busy_q, busy_d;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic [ADDR_BITS-1:0]        out_addr_q, out_addr_d;
    logic                        out_last_q, out_last_d;
    logic                        out_err_q, out_err_d;

    logic                        accept;
    logic [ADDR_BITS-1:0]        idx_inc;

    // Addresses past NUM_REGS match no slice, so they read back as zero.
    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH*NUM_REGS-1:0] flat,
                                              input logic [ADDR_BITS-1:0]      a);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == i[ADDR_BITS-1:0]) v = flat[i*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == i[ADDR_BITS-1:0]) hit = 1'b1;
        end
        return hit;
    endfunction

    assign accept  = out_valid_q && out_ready;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d     = SCAN;
                    snap_d      = regs_flat;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = regs_flat[WIDTH-1:0];
                    out_addr_d  = '0;
                    out_last_d  = (LAST_IDX == '0);
                    out_err_d   = 1'b0;
                end else if (rd_req) begin
                    state_d     = SINGLE;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = pick(regs_flat, rd_addr);
                    out_addr_d  = rd_addr;
                    out_last_d  = 1'b1;
                    out_err_d   = !in_range(rd_addr);
                end
            end
            SINGLE: begin
                if (accept) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_err_d   = 1'b0;
                end
            end
            SCAN: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        // Next beat is preloaded so the stream runs one per cycle.
                        idx_d      = idx_inc;
                        out_data_d = pick(snap_q, idx_inc);
                        out_addr_d = idx_inc;
                        out_last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_register_file_reader.sv
// Bench for register_file_reader: directed scenarios plus random traffic against a beat-queue model.
module tb_register_file_reader;

    localparam int W = 2;
    localparam int N = 4;
    localparam int A = 3;
    localparam logic [7:0] FLAT = 8'b01_10_11_00;

    logic           clk;
    logic           reset;
    logic [W*N-1:0] regs_flat;
    logic           rd_req;
    logic [A-1:0]   rd_addr;
    logic           scan_start;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [A-1:0]   out_addr;
    logic           out_last;
    logic           out_err;

    register_file_reader #(.WIDTH(W), .NUM_REGS(N), .ADDR_BITS(A)) dut (
        .clk        (clk),
        .reset      (reset),
        .regs_flat  (regs_flat),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .scan_start (scan_start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .out_err    (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] d;
        logic [A-1:0] a;
        logic         l;
        logic         e;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a transaction becomes the list of beats it must produce, in order.
    task automatic push_scan(input logic [7:0] flat);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.d = flat[i*W +: W];
            b.a = A'(i);
            b.l = (i == N - 1);
            b.e = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic push_single(input logic [A-1:0] ad, input logic [7:0] flat);
        beat_t b;
        b.a = ad;
        b.l = 1'b1;
        if (int'(ad) < N) begin
            b.d = flat[int'(ad)*W +: W];
            b.e = 1'b0;
        end else begin
            b.d = '0;
            b.e = 1'b1;
        end
        exp_q.push_back(b);
    endtask

    // Called 1 time unit after a rising edge: check outputs, drive inputs for the next edge.
    task automatic cycle(input logic sc, input logic rq, input logic [A-1:0] ad,
                         input logic rdy, input logic [7:0] flat);
        bit idle;
        idle = (exp_q.size() == 0);
        check("busy", 16'(busy), 16'(!idle));
        check("out_valid", 16'(out_valid), 16'(!idle));
        if (!idle && out_valid) begin
            check("out_data", 16'(out_data), 16'(exp_q[0].d));
            check("out_addr", 16'(out_addr), 16'(exp_q[0].a));
            check("out_last", 16'(out_last), 16'(exp_q[0].l));
            check("out_err",  16'(out_err),  16'(exp_q[0].e));
        end
        scan_start = sc;
        rd_req     = rq;
        rd_addr    = ad;
        out_ready  = rdy;
        regs_flat  = flat;
        if (!idle && rdy) void'(exp_q.pop_front());
        if (idle) begin
            if (sc)      push_scan(flat);
            else if (rq) push_single(ad, flat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        regs_flat  = FLAT;
        rd_req     = 1'b0;
        rd_addr    = '0;
        scan_start = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_last",  16'(out_last), 16'h0);
        check("rst_err",   16'(out_err), 16'h0);
        check("rst_data",  16'(out_data), 16'h0);
        check("rst_addr",  16'(out_addr), 16'h0);
        reset = 1'b0;

        // Single read of reg1.
        cycle(0, 1, 3'd1, 1, FLAT);
        check("single_data", 16'(out_data), 16'h3);
        check("single_last", 16'(out_last), 16'h1);
        cycle(0, 0, 3'd0, 1, FLAT);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Scan under 3 cycles of backpressure, then drain.
        cycle(1, 0, 3'd0, 0, FLAT);
        repeat (3) cycle(0, 0, 3'd0, 0, FLAT);
        repeat (4) cycle(0, 0, 3'd0, 1, FLAT);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Register file rewritten right after the scan snapshot.
        cycle(1, 0, 3'd0, 1, FLAT);
        repeat (4) cycle(0, 0, 3'd0, 1, 8'hFF);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Scan beats rd_req; rd_req mid-scan ignored; rd_req after final accept served.
        cycle(1, 1, 3'd2, 1, FLAT);
        repeat (4) cycle(0, 1, 3'd2, 1, FLAT);
        cycle(0, 1, 3'd2, 1, FLAT);
        check("post_scan_data", 16'(out_data), 16'h2);
        check("post_scan_addr", 16'(out_addr), 16'h2);
        cycle(0, 0, 3'd0, 1, FLAT);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Out-of-range single read.
        cycle(0, 1, 3'd5, 1, FLAT);
        check("oor_err",  16'(out_err), 16'h1);
        check("oor_data", 16'(out_data), 16'h0);
        check("oor_addr", 16'(out_addr), 16'h5);
        cycle(0, 0, 3'd0, 1, FLAT);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Reset between edges while the scan shows index 2.
        cycle(1, 0, 3'd0, 1, FLAT);
        repeat (2) cycle(0, 0, 3'd0, 1, FLAT);
        check("pre_rst_addr", 16'(out_addr), 16'h2);
        #2;
        reset      = 1'b1;
        scan_start = 1'b0;
        rd_req     = 1'b0;
        #1;
        check("midrst_valid", 16'(out_valid), 16'h0);
        check("midrst_busy",  16'(busy), 16'h0);
        check("midrst_last",  16'(out_last), 16'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, 0, 3'd0, 1, FLAT);
        check("rescan_addr", 16'(out_addr), 16'h0);
        repeat (4) cycle(0, 0, 3'd0, 1, FLAT);
        cycle(0, 0, 3'd0, 1, FLAT);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(7) == 0), ($urandom_range(3) == 0), A'($urandom_range(7)),
                  ($urandom_range(2) != 0), 8'($urandom));
        end
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 3'd0, 1, 8'($urandom));
        end
        check("drained", 16'(exp_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
